// File: rtl/pio_status_pkg.sv
// pio_status_pkg: register map, mode encodings and counter width shared by the status capture PIO.
package pio_status_pkg;
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_EVCOUNT = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
    localparam int IRQ_SRC_EDGE  = 0;
    localparam int IRQ_SRC_LEVEL = 1;
    localparam int EVCOUNT_WIDTH = 16;
endpackage

// File: rtl/pio_input_sync.sv
// pio_input_sync: multi-stage synchronizer for the status bus plus one delayed copy for edge detection.
module pio_input_sync
    import pio_status_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port_i,
    output logic [DATA_WIDTH-1:0] sync_o,
    output logic [DATA_WIDTH-1:0] edge_o
);
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] stage_q;
    logic [DATA_WIDTH-1:0]                  prev_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            stage_q <= '0;
            prev_q  <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], in_port_i};
            prev_q  <= stage_q[SYNC_STAGES-1];
        end
    assign sync_o = stage_q[SYNC_STAGES-1];
    assign edge_o = EDGE_MODE == EDGE_FALL ? ~sync_o & prev_q :
                    EDGE_MODE == EDGE_ANY  ? sync_o ^ prev_q  : sync_o & ~prev_q;
endmodule

// File: rtl/pio_status_capture.sv
// pio_status_capture: Avalon-MM input PIO with edge capture, irq mask and a saturating masked-edge counter.
module pio_status_capture
    import pio_status_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE,
    parameter int IRQ_MODE    = IRQ_SRC_EDGE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);
    logic [DATA_WIDTH-1:0]    sync, edges, mask_q, mask_d, cap_q, cap_d;
    logic [EVCOUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     wr, hit;
    pio_input_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_MODE  (EDGE_MODE)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port_i(in_port),
        .sync_o   (sync),
        .edge_o   (edges)
    );
    assign wr  = chipselect & ~write_n;
    assign hit = |(edges & mask_q);
    always_comb begin
        mask_d  = wr && address == ADDR_IRQMASK ? writedata[DATA_WIDTH-1:0] : mask_q;
        cap_d   = (cap_q & ~(wr && address == ADDR_EDGECAP ? writedata[DATA_WIDTH-1:0] : '0)) | edges;
        cnt_d   = wr && address == ADDR_EVCOUNT ? EVCOUNT_WIDTH'(hit) :
                  hit && cnt_q != '1            ? cnt_q + EVCOUNT_WIDTH'(1) : cnt_q;
        rdata_d = address == ADDR_DATA    ? 32'(sync)   :
                  address == ADDR_IRQMASK ? 32'(mask_q) :
                  address == ADDR_EDGECAP ? 32'(cap_q)  : 32'(cnt_q);
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mask_q  <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    assign readdata = rdata_q;
    // Both sources are flop outputs, so the OR-reduce cannot glitch on input activity.
    assign irq = |((IRQ_MODE == IRQ_SRC_LEVEL ? sync : cap_q) & mask_q);
endmodule

// File: tb/tb_pio_status_capture.sv
// tb_pio_status_capture: scoreboard bench for a default instance (u=0) and an 8-bit any-edge/level-irq instance (u=1).
module tb_pio_status_capture;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  addr [2];
    logic        cs [2];
    logic        wn [2];
    logic [31:0] wd [2];
    logic [31:0] rdata [2];
    logic        irq [2];
    logic [31:0] a_in;
    logic [7:0]  b_in;
    int          checks = 0;
    int          errors = 0;
    string       tq[$];
    logic [31:0] eq[$];

    always #5 clk = ~clk;

    pio_status_capture u_a (
        .clk(clk), .reset_n(reset_n), .address(addr[0]), .chipselect(cs[0]), .write_n(wn[0]),
        .writedata(wd[0]), .readdata(rdata[0]), .in_port(a_in), .irq(irq[0])
    );
    pio_status_capture #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(2), .IRQ_MODE(1)) u_b (
        .clk(clk), .reset_n(reset_n), .address(addr[1]), .chipselect(cs[1]), .write_n(wn[1]),
        .writedata(wd[1]), .readdata(rdata[1]), .in_port(b_in), .irq(irq[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int u, input logic [1:0] a, input logic [31:0] d);
        cs[u] = 1'b1; wn[u] = 1'b0; addr[u] = a; wd[u] = d;
        tick;
        cs[u] = 1'b0; wn[u] = 1'b1;
    endtask

    task automatic rd(input int u, input logic [1:0] a, input logic [31:0] e, input string tag);
        addr[u] = a;
        tq.push_back(tag);
        eq.push_back(e);
        tick;
        chk(tq.pop_front(), rdata[u], eq.pop_front());
    endtask

    initial begin
        reset_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            addr[u] = 2'd0; cs[u] = 1'b0; wn[u] = 1'b1; wd[u] = '0;
        end
        a_in = 32'h1;
        b_in = 8'h0;
        repeat (2) tick;
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_irq", 32'(irq[0]), 32'h0);
        reset_n = 1'b1;
        // input held high through reset appears in DATA after SYNC_STAGES+1 clocks
        tick; tick;
        chk("data_lat_early", rdata[0], 32'h0);
        tick;
        chk("data_lat", rdata[0], 32'h1);
        rd(0, 2'd2, 32'h1, "rst_edgecap");
        rd(0, 2'd3, 32'h0, "rst_evcount");
        chk("rst_irq_unmasked", 32'(irq[0]), 32'h0);

        wr(0, 2'd1, 32'h0F);
        chk("mask_prewrite", rdata[0], 32'h0);
        rd(0, 2'd1, 32'h0F, "mask");
        wr(0, 2'd2, 32'hFFFF_FFFF);
        wr(0, 2'd3, 32'h0);
        rd(0, 2'd2, 32'h0, "cap_cleared");

        a_in = 32'h5; tick; a_in = 32'h1;
        repeat (3) tick;
        chk("pulse_irq", 32'(irq[0]), 32'h1);
        rd(0, 2'd2, 32'h4, "pulse_cap");
        rd(0, 2'd3, 32'h1, "pulse_count");
        wr(0, 2'd2, 32'h4);
        chk("w1c_irq", 32'(irq[0]), 32'h0);
        rd(0, 2'd2, 32'h0, "w1c_cap");

        a_in = 32'h9; repeat (3) tick;
        a_in = 32'h1; repeat (3) tick;
        rd(0, 2'd2, 32'h8, "bit3_cap");
        a_in = 32'h9; tick; tick;
        wr(0, 2'd2, 32'h8);
        chk("setwins_irq", 32'(irq[0]), 32'h1);
        rd(0, 2'd2, 32'h8, "setwins_cap");

        wr(1, 2'd1, 32'hFFFF_FFFF);
        rd(1, 2'd1, 32'hFF, "b_mask_width");
        wr(1, 2'd1, 32'h80);
        b_in = 8'h80; tick;
        chk("b_lvl_irq_early", 32'(irq[1]), 32'h0);
        tick;
        chk("b_lvl_irq", 32'(irq[1]), 32'h1);
        rd(1, 2'd0, 32'h80, "b_data");
        b_in = 8'h40; tick; tick;
        chk("b_lvl_irq_off", 32'(irq[1]), 32'h0);

        wr(1, 2'd1, 32'h1);
        wr(1, 2'd3, 32'h0);
        for (int i = 0; i < 65540; i++) begin
            b_in[0] = ~b_in[0];
            tick;
        end
        repeat (4) tick;
        rd(1, 2'd3, 32'hFFFF, "b_saturate");
        repeat (3) begin
            b_in[0] = ~b_in[0];
            tick;
        end
        cs[1] = 1'b1; wn[1] = 1'b0; addr[1] = 2'd3; wd[1] = 32'h0;
        b_in[0] = ~b_in[0];
        tick;
        cs[1] = 1'b0; wn[1] = 1'b1;
        rd(1, 2'd3, 32'h1, "b_clear_with_edge");

        a_in = 32'h0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_irq", 32'(irq[0]), 32'h0);
        chk("async_rst_rdata", rdata[0], 32'h0);
        tick;
        reset_n = 1'b1;
        rd(0, 2'd1, 32'h0, "post_rst_mask");
        rd(0, 2'd2, 32'h0, "post_rst_cap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pio_status_capture.md
# pio_status_capture

Parametrised Avalon-MM input PIO slave for the VGA image viewer, the successor to the plain pixel-status input port. It samples an asynchronous status bus through a synchronizer and exposes the synchronized value. It also provides per-bit edge capture with write-1-to-clear, an interrupt mask and irq output, and a saturating event counter. Nios II software uses it to observe frame/pixel status without polling every cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, width of in_port and of the data/mask/capture registers (1..32)
- SYNC_STAGES, 2, synchronizer flop count on in_port (2..4)
- EDGE_MODE, 0, edge detected: 0 rising, 1 falling, 2 any
- IRQ_MODE, 0, irq source: 0 edge capture, 1 level on synchronized data

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  DATA_WIDTH  asynchronous status inputs
- irq  out  1  interrupt request, active high

## Operation
- Register map, unused upper bits read 0 and ignore writes:
  - 0 DATA (RO): synchronized in_port.
  - 1 IRQMASK (RW): DATA_WIDTH bits.
  - 2 EDGECAP (RW1C): a bit sets on a detected edge of that input; writing 1 clears it; writing 0 has no effect.
  - 3 EVCOUNT (RO bits 15:0, any write clears): number of cycles in which at least one masked edge was detected. Saturates at 0xFFFF.
- Write occurs when chipselect=1 and write_n=0. Writes to DATA are ignored.
- Edge detect compares the last synchronizer stage (sync) with one further delayed copy (prev): rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev.
- Simultaneous W1C and new edge on the same bit: the set wins, and the bit stays 1.
- Simultaneous EVCOUNT clear and masked edge: the counter becomes 1.
- irq:
  - IRQ_MODE 0: |(EDGECAP & IRQMASK).
  - IRQ_MODE 1: |(sync & IRQMASK).
  - irq is driven from registers only and is glitch-free.
- Reset values:
  - readdata, irq: 0.
  - IRQMASK, EDGECAP, EVCOUNT, all synchronizer and prev flops: 0.
- Consequence of resetting the synchronizer to 0: an input held high through reset release is seen as a rising (or any) edge once it reaches sync. This is required behaviour.

## Timing
- readdata is updated every clock from the current address, independent of chipselect. Read latency is 1 cycle.
- A read in the same cycle as a write to the same register returns the pre-write value.
- in_port to DATA visible: SYNC_STAGES cycles after the input is sampled.
- Edge to EDGECAP bit set: the edge is detected in the cycle after sync changes, and the bit is set at the end of that cycle.
- EDGECAP to irq (IRQ_MODE 0): 0 cycles, combinational from registers.
- Write effects (W1C, mask update, counter clear) take effect at the clock edge of the write cycle.
- Asserting reset mid-operation clears all state immediately, with no pending write completion.

## Structure
- Shared package pio_status_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=2, ADDR_EVCOUNT=3;
  - EDGE_MODE encodings EDGE_RISE/EDGE_FALL/EDGE_ANY;
  - IRQ_MODE encodings;
  - EVCOUNT_WIDTH=16.
- Sub-module pio_input_sync contains the DATA_WIDTH-wide SYNC_STAGES synchronizer, the prev register and the EDGE_MODE edge detector. It outputs sync and an edge vector.
- The top level holds the register file, read mux, counter and irq logic.

## Test plan
- Reset release with in_port=0x00000001, EDGE_MODE 0 -> DATA reads 0x1 after SYNC_STAGES+1 cycles; EDGECAP reads 0x1; EVCOUNT stays 0 because IRQMASK=0.
- IRQMASK=0x0F, pulse in_port bit 2 high for 1 cycle -> EDGECAP=0x4, irq=1, EVCOUNT=1; write 0x4 to EDGECAP -> EDGECAP=0, irq=0 the next cycle.
- W1C of bit 3 in the same cycle a new rising edge on bit 3 is detected -> EDGECAP bit 3 remains 1 and irq stays asserted.
- IRQMASK=0x1, toggle bit 0 for 70000 edges -> EVCOUNT saturates at 0xFFFF; write to address 3 coincident with an edge -> EVCOUNT=1.
- EDGE_MODE 2, IRQ_MODE 1, DATA_WIDTH 8: input 0x80 with IRQMASK=0x80 -> irq follows the synchronized bit 7 level; a read of address 0 returns 0x00000080 with upper bits 0, one cycle after address is presented.
